// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- generic pipeline-stage register between two pipe stages.
//
// Carries one WIDTH-bit packed bundle (instruction, PC, operands, control)
// with a valid/ready handshake, hazard-unit enable/flush, bubble insertion on
// drain, and a saturating back-pressure counter.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   -> 2-entry elastic stage (EMPTY/ONE/TWO);
//                                    in_ready depends only on registered state.
//                       undefined -> single-entry stage, latency 1;
//                                    occupancy[1] is tied 0 and there is no skid storage.
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   en              hazard-unit enable; 0 freezes the held entries
//   flush           synchronous squash of every held entry
//   in_valid/in_ready/in_data     upstream handshake and bundle
//   out_valid/out_ready/out_data  downstream handshake and bundle
//   occupancy       number of held entries
//   stall_cycles    saturating count of edges with out_valid & !out_ready
module pipe_stage_reg #(
  parameter int               WIDTH     = 128,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] data_nx;

  assign accept = in_valid & in_ready;  // in_ready already folds in en & !flush
  assign pop    = out_valid & out_ready & en & ~flush;

  // Stall counter keeps counting through en=0 and flush: it measures what the
  // consumer saw, not what this stage did.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      stall_cycles <= '0;
    else if (out_valid && !out_ready && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] skid, skid_nx;

  // Ready is a pure function of the registered state (plus hazard controls),
  // so it never sees out_ready combinationally.
  assign in_ready  = en & ~flush & (state != TWO);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= EMPTY;
      out_data <= FLUSH_VAL;
      skid     <= FLUSH_VAL;
    end else begin
      state    <= state_nx;
      out_data <= data_nx;
      skid     <= skid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    data_nx  = out_data;
    skid_nx  = skid;
    if (flush) begin
      state_nx = EMPTY;
      data_nx  = FLUSH_VAL;
      skid_nx  = FLUSH_VAL;
    end else if (en) begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nx = ONE;
            data_nx  = in_data;
          end
        end
        ONE: begin
          if (accept && pop) begin
            data_nx = in_data;
          end else if (accept) begin
            // Consumer stalled: park the newcomer behind the head entry.
            state_nx = TWO;
            skid_nx  = in_data;
          end else if (pop) begin
            state_nx = EMPTY;
            data_nx  = FLUSH_VAL;
          end
        end
        TWO: begin
          if (pop) begin
            state_nx = ONE;
            data_nx  = skid;
            skid_nx  = FLUSH_VAL;
          end
        end
        default: begin
          state_nx = EMPTY;
          data_nx  = FLUSH_VAL;
          skid_nx  = FLUSH_VAL;
        end
      endcase
    end
  end

`else

  logic valid_nx;

  // Refill in the same cycle the head drains, so streaming has no bubbles.
  assign in_ready  = en & ~flush & (~out_valid | out_ready);
  assign occupancy = {1'b0, out_valid};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_data  <= FLUSH_VAL;
    end else begin
      out_valid <= valid_nx;
      out_data  <= data_nx;
    end
  end

  always_comb begin
    valid_nx = out_valid;
    data_nx  = out_data;
    if (flush) begin
      valid_nx = 1'b0;
      data_nx  = FLUSH_VAL;
    end else if (accept) begin
      valid_nx = 1'b1;
      data_nx  = in_data;
    end else if (pop) begin
      // Drained without refill: present a NOP bubble downstream.
      valid_nx = 1'b0;
      data_nx  = FLUSH_VAL;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg -- directed + random stimulus against a queue model.
// The model is a FIFO of held bundles with capacity 1 (or 2 with
// PIPE_STAGE_SKID_EN); a second instance with CNT_W=4 checks saturation.
module tb_pipe_stage_reg;
  localparam int W = 32;
  localparam logic [W-1:0] FV = 32'h0BAD_F00D;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic CLK = 1'b0;
  logic RST, en, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic [15:0]  stall_cycles;

  logic         s_in_ready, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_occupancy;
  logic [3:0]   s_stall_cycles;

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.WIDTH(W), .FLUSH_VAL(FV), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  pipe_stage_reg #(.WIDTH(W), .CNT_W(4)) dut_sat (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cycles(s_stall_cycles)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: held bundles in arrival order, plus two counters.
  logic [W-1:0] q[$];
  int unsigned  m_stall = 0;
  int unsigned  m_stall_sat = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready();
    logic room;
    if (CAP == 2) room = (q.size() < 2);
    else          room = (q.size() == 0) || out_ready;
    return en && !flush && room;
  endfunction

  task automatic check_outputs();
    chk("in_ready",    {63'd0, in_ready},    {63'd0, exp_ready()});
    chk("out_valid",   {63'd0, out_valid},   {63'd0, q.size() != 0});
    chk("out_data",    {32'd0, out_data},    {32'd0, (q.size() != 0) ? q[0] : FV});
    chk("occupancy",   {62'd0, occupancy},   64'(q.size()));
    chk("stall",       {48'd0, stall_cycles}, 64'(m_stall));
    chk("sat_ready",   {63'd0, s_in_ready},  {63'd0, exp_ready()});
    chk("sat_data",    {32'd0, s_out_data},  {32'd0, (q.size() != 0) ? q[0] : 32'd0});
    chk("sat_stall",   {60'd0, s_stall_cycles}, 64'(m_stall_sat));
  endtask

  // Apply the rules of one clock edge to the model using the current inputs.
  task automatic model_edge();
    logic acc, pp;
    acc = in_valid && exp_ready();
    pp  = (q.size() != 0) && out_ready;
    if ((q.size() != 0) && !out_ready) begin
      if (m_stall < 16'hFFFF) m_stall++;
      if (m_stall_sat < 15)   m_stall_sat++;
    end
    if (flush) q.delete();
    else if (en) begin
      if (pp)  void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r,
                       input logic e, input logic f);
    in_valid = v; in_data = d; out_ready = r; en = e; flush = f;
    #1;
    check_outputs();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    #2 RST = 1'b1;
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data",  {32'd0, out_data},  {32'd0, FV});
    chk("rst_occ",   {62'd0, occupancy}, 64'd0);
    chk("rst_stall", {48'd0, stall_cycles}, 64'd0);
    chk("rst_sstall", {60'd0, s_stall_cycles}, 64'd0);
    q.delete();
    m_stall = 0;
    m_stall_sat = 0;
    #1 RST = 1'b0;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  initial begin
    logic [W-1:0] hd;
    int unsigned  base;
    RST = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #2;
    chk("init_valid", {63'd0, out_valid}, 64'd0);
    chk("init_data",  {32'd0, out_data},  {32'd0, FV});
    chk("init_occ",   {62'd0, occupancy}, 64'd0);
    chk("init_stall", {48'd0, stall_cycles}, 64'd0);
    #1 RST = 1'b0;
    @(posedge CLK);
    model_edge();
    #1;

    // Reset mid-stream with a held bundle and a nonzero stall count.
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_data", {32'd0, out_data}, {32'd0, 32'hDEAD_BEEF});
    reset_pulse();

    // Streaming 1..8 with the consumer always ready.
    for (int i = 1; i <= 8; i++) cycle(1'b1, W'(i), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)  cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    chk("stream_stall", {48'd0, stall_cycles}, 64'd0);

    // Back-pressure for 5 cycles, then release.
    base = m_stall;
    cycle(1'b1, 32'd100, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(101 + i), 1'b0, 1'b1, 1'b0);
    chk("bp_stall", {48'd0, stall_cycles}, 64'(base + 5));
    chk("bp_head",  {32'd0, out_data}, {32'd0, 32'd100});
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    // Flush races an accept: 8'hAA must never surface.
    cycle(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'hAA, 1'b1, 1'b1, 1'b1);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_data",  {32'd0, out_data}, {32'd0, FV});
    for (int i = 0; i < 2; i++) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    // Enable freeze with a held bundle.
    cycle(1'b1, 32'h1234, 1'b0, 1'b1, 1'b0);
    hd = 32'h1234;
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h9999, 1'b1, 1'b0, 1'b0);
    chk("freeze_head", {32'd0, out_data}, {32'd0, hd});
    cycle(1'b1, 32'h5678, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    // Saturation of the 4-bit counter.
    cycle(1'b1, 32'h77, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("sat_15", {60'd0, s_stall_cycles}, 64'd15);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("sat_hold", {60'd0, s_stall_cycles}, 64'd15);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    // Random traffic with occasional hazards and resets.
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) reset_pulse();
      else cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
                 ($urandom % 8) != 0, ($urandom % 16) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
